// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: request/command bundle plus
// the registered completion response.
// Handshake: the requester raises req with we/addr/wdata stable and holds them
// until it sees ack (a one-cycle pulse); rdata and err are valid only while ack
// is high. A req still high in the cycle after ack counts as a new request.
interface data_mem_arbiter_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between two requesters with round-robin or
// fixed-priority arbitration, address range checking and registered responses.
module data_mem_arbiter #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 24,
    parameter int MEM_DEPTH  = 1024,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_arbiter_if.slave    p0,
    data_mem_arbiter_if.slave    p1,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_write_data,
    output logic                 mem_write,
    output logic                 mem_read,
    input  logic [DATA_W-1:0]    mem_read_data,
    output logic [1:0]           fsm_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

    state_t            state, state_nxt;
    logic              gnt;
    logic              last_grant;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              any_req;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign any_req = p0.req | p1.req;

    // On a tie round-robin hands the grant to the port that did not win last.
    always_comb begin
        win = 1'b0;
        if (FIXED_PRIO != 0)
            win = ~p0.req;
        else if (p0.req && p1.req)
            win = ~last_grant;
        else
            win = ~p0.req;
        win_we    = win ? p1.we    : p0.we;
        win_addr  = win ? p1.addr  : p0.addr;
        win_wdata = win ? p1.wdata : p0.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Memory strobes are gated with reset so an access aborted by reset is never committed.
    always_comb begin
        state_nxt      = state;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        p0.ack         = 1'b0;
        p0.err         = 1'b0;
        p1.ack         = 1'b0;
        p1.err         = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                mem_write      = we_q & ~err_q & ~reset;
                mem_read       = ~we_q & ~err_q & ~reset;
                state_nxt      = RESP;
            end
            RESP: begin
                p0.ack    = ~gnt & ~reset;
                p0.err    = ~gnt & err_q & ~reset;
                p1.ack    = gnt & ~reset;
                p1.err    = gnt & err_q & ~reset;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= win;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        err_q   <= ~(win_addr < DEPTH_A);
                    end
                end
                ACCESS: begin
                    if (!we_q && !err_q) begin
                        if (gnt)
                            rdata1_q <= mem_read_data;
                        else
                            rdata0_q <= mem_read_data;
                    end
                end
                RESP: last_grant <= gnt;
                default: ;
            endcase
        end
    end

    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;
    assign fsm_state = state;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a table of single-port transactions
// plus hand-timed sequences for contention, fixed priority, late requests and reset abort.
module tb_data_mem_arbiter;
    localparam int DW = 24;
    localparam int AW = 24;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    logic load = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance with a behavioural 1Kx24 memory
    data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) p0_bus ();
    data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) p1_bus ();
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_write, mem_read;
    logic [1:0]    fsm_state;
    logic [DW-1:0] mem [0:1023];
    int            wr_cnt = 0;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(1024), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .reset(reset), .p0(p0_bus), .p1(p1_bus),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .fsm_state(fsm_state)
    );

    assign mem_read_data = (mem_address < 24'd1024) ? mem[mem_address[9:0]] : '0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= DW'(i * 3);
        end else if (mem_write) begin
            mem[mem_address[9:0]] <= mem_write_data;
        end
        if (mem_write) wr_cnt <= wr_cnt + 1;
    end

    // fixed-priority instance with a read-only mock returning the address
    data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) f0_bus ();
    data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) f1_bus ();
    logic [AW-1:0] f_mem_address;
    logic [DW-1:0] f_mem_write_data, f_mem_read_data;
    logic          f_mem_write, f_mem_read;
    logic [1:0]    f_fsm_state;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(1024), .FIXED_PRIO(1)) u_fix (
        .clk(clk), .reset(reset), .p0(f0_bus), .p1(f1_bus),
        .mem_address(f_mem_address), .mem_write_data(f_mem_write_data),
        .mem_write(f_mem_write), .mem_read(f_mem_read),
        .mem_read_data(f_mem_read_data), .fsm_state(f_fsm_state)
    );

    assign f_mem_read_data = {14'h0, f_mem_address[9:0]};

    // scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(logic port, logic we, logic [AW-1:0] addr,
                                logic [DW-1:0] wdata, logic exp_err, logic [DW-1:0] exp_rdata);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // driver tasks
    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
        end else begin
            p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One isolated transaction: request at a negedge in IDLE, ack expected two cycles later.
    task automatic run_vec(input vec_t v, input int idx);
        int start_wr;
        int lat;
        logic ack_v, oack_v, err_v;
        logic [DW-1:0] rd_v;
        lat = 0; err_v = 1'b0; rd_v = '0; oack_v = 1'b0;
        @(negedge clk);
        start_wr = wr_cnt;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ack_v  = v.port ? p1_bus.ack : p0_bus.ack;
            oack_v = v.port ? p0_bus.ack : p1_bus.ack;
            if (ack_v) begin
                lat   = k;
                err_v = v.port ? p1_bus.err : p0_bus.err;
                rd_v  = v.port ? p1_bus.rdata : p0_bus.rdata;
                break;
            end
        end
        drive(v.port, 1'b0, 1'b0, '0, '0);
        chk($sformatf("vec%0d latency", idx), lat, 2);
        chk($sformatf("vec%0d err", idx), {31'b0, err_v}, {31'b0, v.exp_err});
        chk($sformatf("vec%0d rdata", idx), {8'b0, rd_v}, {8'b0, v.exp_rdata});
        chk($sformatf("vec%0d other_ack", idx), {31'b0, oack_v}, 0);
        chk($sformatf("vec%0d mem_write_pulses", idx), wr_cnt - start_wr,
            (v.we && !v.exp_err) ? 1 : 0);
    endtask

    vec_t vecs[13];

    initial begin
        reset = 1'b1;
        load  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        f0_bus.req = 1'b0; f0_bus.we = 1'b0; f0_bus.addr = '0; f0_bus.wdata = '0;
        f1_bus.req = 1'b0; f1_bus.we = 1'b0; f1_bus.addr = '0; f1_bus.wdata = '0;

        vecs[0]  = mk(1'b0, 1'b1, 24'd5,       24'hABCDEF, 1'b0, 24'h000000);
        vecs[1]  = mk(1'b0, 1'b0, 24'd5,       24'h000000, 1'b0, 24'hABCDEF);
        vecs[2]  = mk(1'b1, 1'b1, 24'd1024,    24'h555555, 1'b1, 24'h000000);
        vecs[3]  = mk(1'b1, 1'b0, 24'd0,       24'h000000, 1'b0, 24'h000000);
        vecs[4]  = mk(1'b1, 1'b1, 24'd1023,    24'h123456, 1'b0, 24'h000000);
        vecs[5]  = mk(1'b0, 1'b0, 24'd1023,    24'h000000, 1'b0, 24'h123456);
        vecs[6]  = mk(1'b1, 1'b0, 24'd10,      24'h000000, 1'b0, 24'h00001E);
        vecs[7]  = mk(1'b1, 1'b1, 24'h000405,  24'h999999, 1'b1, 24'h00001E);
        vecs[8]  = mk(1'b0, 1'b0, 24'd5,       24'h000000, 1'b0, 24'hABCDEF);
        vecs[9]  = mk(1'b0, 1'b0, 24'h010005,  24'h000000, 1'b1, 24'hABCDEF);
        vecs[10] = mk(1'b1, 1'b0, 24'd1023,    24'h000000, 1'b0, 24'h123456);
        vecs[11] = mk(1'b0, 1'b1, 24'd0,       24'h0F0F0F, 1'b0, 24'hABCDEF);
        vecs[12] = mk(1'b1, 1'b0, 24'd0,       24'h000000, 1'b0, 24'h0F0F0F);

        repeat (2) @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst fsm_state", {30'b0, fsm_state}, 0);
        chk("rst acks_errs", {28'b0, p0_bus.ack, p0_bus.err, p1_bus.ack, p1_bus.err}, 0);
        chk("rst rdata", {p0_bus.rdata[15:0], p1_bus.rdata[15:0]} | {8'b0, p0_bus.rdata | p1_bus.rdata}, 0);
        chk("rst mem_strobes", {30'b0, mem_write, mem_read}, 0);
        chk("rst mem_bus", {8'b0, mem_address | mem_write_data}, 0);
        chk("rst fixed", {24'b0, f_fsm_state, f_mem_write, f_mem_read, f1_bus.ack, f0_bus.ack,
                          |f_mem_write_data, |f_mem_address}, 0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // both ports reading continuously from reset: grants alternate 0,1,0,1
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 24'd20, '0);
        drive(1'b1, 1'b1, 1'b0, 24'd21, '0);
        for (int k = 1; k <= 11; k++) begin
            logic e0, e1;
            @(negedge clk);
            e0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
            chk($sformatf("rr k%0d acks", k), {30'b0, p0_bus.ack, p1_bus.ack}, {30'b0, e0, e1});
            if (e0) chk($sformatf("rr k%0d p0_rdata", k), {8'b0, p0_bus.rdata}, 32'h3C);
            if (e1) chk($sformatf("rr k%0d p1_rdata", k), {8'b0, p1_bus.rdata}, 32'h3F);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // fixed priority: p0 always wins, p1 served once p0 drops
        @(negedge clk);
        f0_bus.req = 1'b1; f0_bus.addr = 24'd3;
        f1_bus.req = 1'b1; f1_bus.addr = 24'd4;
        for (int k = 1; k <= 12; k++) begin
            logic e0, e1;
            @(negedge clk);
            e0 = (k == 2) || (k == 5) || (k == 8);
            e1 = (k == 11);
            chk($sformatf("fix k%0d acks", k), {30'b0, f0_bus.ack, f1_bus.ack}, {30'b0, e0, e1});
            if (e0) chk($sformatf("fix k%0d f0_rdata", k), {8'b0, f0_bus.rdata}, 3);
            if (e1) chk($sformatf("fix k%0d f1_rdata", k), {8'b0, f1_bus.rdata}, 4);
            if (k == 8) f0_bus.req = 1'b0;
            if (k == 11) f1_bus.req = 1'b0;
        end

        // p1 raises req while p0 is in ACCESS; served in the following IDLE
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 24'd10, '0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("late k%0d acks", k), {30'b0, p0_bus.ack, p1_bus.ack},
                {30'b0, k == 2, k == 5});
            if (k == 1) drive(1'b1, 1'b1, 1'b0, 24'd0, '0);
            if (k == 2) drive(1'b0, 1'b0, 1'b0, '0, '0);
            if (k == 5) begin
                chk("late p1_rdata", {8'b0, p1_bus.rdata}, 32'h0F0F0F);
                drive(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end

        // reset arriving during the ACCESS cycle of a write aborts it
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 24'd7, 24'h777777);
        @(negedge clk);
        chk("abort pre mem_write", {31'b0, mem_write}, 1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("abort gated strobes", {30'b0, mem_write, mem_read}, 0);
        @(negedge clk);
        chk("abort no ack", {30'b0, p0_bus.ack, p0_bus.err}, 0);
        chk("abort fsm_state", {30'b0, fsm_state}, 0);
        chk("abort mem_bus", {7'b0, mem_write, mem_address | mem_write_data}, 0);
        reset = 1'b0;
        run_vec(mk(1'b0, 1'b0, 24'd7, 24'h000000, 1'b0, 24'h000015), 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
